exe_issue_ctrl: RTL and testbench

Issue/collect controller that drives two-cycle EXE arithmetic units through their start/Op/a/b → valid/result handshake.
- Accepts tagged operations from decode into a small FIFO.
- Sequences each operation through the EXE unit's handshake and timing rules.
- Returns result plus tag on a valid/ready writeback port.
- One outstanding EXE operation at a time; sits between decode and the register-file writeback arbiter.

---
 rtl/exe_pkg.sv | 31 +++
 rtl/issue_fifo.sv | 50 +++++
 rtl/exe_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_exe_issue_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared types and constants for the EXE issue controller: opcodes, FSM states and the
// writeback record.
package exe_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;

    // Writeback record is sized for the widest supported configuration; the top slices it.
    localparam int unsigned WB_DATA_MAX = 64;
    localparam int unsigned WB_TAG_MAX  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStart,
        StWait,
        StWb,
        StGap
    } state_t;

    typedef struct packed {
        logic [WB_TAG_MAX-1:0]  tag;
        logic [WB_DATA_MAX-1:0] data;
        logic                   err;
    } wb_rec_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Count-based FIFO holding decoded operations until their writeback is accepted.
module issue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/exe_issue_ctrl.sv
// Issue/collect controller: queues tagged ops, runs each through the two-cycle EXE handshake
// and returns result plus tag on a valid/ready writeback port.
module exe_issue_ctrl
    import exe_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              exe_start,
    output logic [2:0]        exe_op,
    output logic [DATA_W-1:0] exe_a,
    output logic [DATA_W-1:0] exe_b,
    input  logic              exe_valid,
    input  logic [DATA_W-1:0] exe_result,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_err,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int unsigned ENTRY_W = 3 + 2 * DATA_W + TAG_W;
    localparam int unsigned TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [ENTRY_W-1:0] head;
    logic [2:0]         head_op;
    logic [DATA_W-1:0]  head_a, head_b;
    logic [TAG_W-1:0]   head_tag;
    logic               fifo_full, fifo_empty, pop;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [2:0]         exe_op_q, exe_op_d;
    logic [DATA_W-1:0]  exe_a_q, exe_a_d, exe_b_q, exe_b_d;
    wb_rec_t            wb_q, wb_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    assign in_ready = !fifo_full;
    assign {head_op, head_a, head_b, head_tag} = head;

    issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .wdata ({in_op, in_a, in_b, in_tag}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            exe_op_q  <= '0;
            exe_a_q   <= '0;
            exe_b_q   <= '0;
            wb_q      <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            exe_op_q  <= exe_op_d;
            exe_a_q   <= exe_a_d;
            exe_b_q   <= exe_b_d;
            wb_q      <= wb_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        exe_op_d  = exe_op_q;
        exe_a_d   = exe_a_q;
        exe_b_d   = exe_b_q;
        wb_d      = wb_q;
        err_cnt_d = err_cnt_q;
        pop       = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    wb_d.tag = WB_TAG_MAX'(head_tag);
                    if (op_legal(head_op)) begin
                        exe_op_d = head_op;
                        exe_a_d  = head_a;
                        exe_b_d  = head_b;
                        state_d  = StSetup;
                    end else begin
                        // Illegal ops complete immediately without touching the EXE unit.
                        wb_d.data = '0;
                        wb_d.err  = 1'b1;
                        state_d   = StWb;
                    end
                end
            end
            StSetup: state_d = StStart;
            StStart: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (exe_valid) begin
                    wb_d.data = WB_DATA_MAX'(exe_result);
                    wb_d.err  = 1'b0;
                    state_d   = StWb;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    wb_d.data = '0;
                    wb_d.err  = 1'b1;
                    state_d   = StWb;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWb: begin
                if (wb_ready) begin
                    pop = 1'b1;
                    if (wb_q.err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
                    state_d = StGap;
                end
            end
            // Keeps exe_start low for a cycle so the EXE unit's counter can clear.
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign exe_start = (state_q == StStart);
    assign exe_op    = exe_op_q;
    assign exe_a     = exe_a_q;
    assign exe_b     = exe_b_q;
    assign wb_valid  = (state_q == StWb);
    assign wb_tag    = wb_q.tag[TAG_W-1:0];
    assign wb_data   = wb_q.data[DATA_W-1:0];
    assign wb_err    = wb_q.err;
    assign busy      = (state_q != StIdle) || !fifo_empty;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Directed self-checking bench for exe_issue_ctrl with a behavioural two-cycle EXE unit.
module tb_exe_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic        exe_start;
    logic [2:0]  exe_op;
    logic [31:0] exe_a, exe_b;
    logic        exe_valid;
    logic [31:0] exe_result;
    logic        wb_valid, wb_ready;
    logic [3:0]  wb_tag;
    logic [31:0] wb_data;
    logic        wb_err, busy;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    // EXE model controls and handshake monitor state
    logic exe_mute = 1'b0;
    logic prev_valid = 1'b0;
    int   cyc = 0;
    int   last_start_cyc = 0;
    int   prev_start_cyc = 0;
    int   start_count = 0;
    int   gap_viol = 0;

    exe_issue_ctrl #(
        .DATA_W  (32),
        .TAG_W   (4),
        .DEPTH   (4),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .exe_start  (exe_start),
        .exe_op     (exe_op),
        .exe_a      (exe_a),
        .exe_b      (exe_b),
        .exe_valid  (exe_valid),
        .exe_result (exe_result),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_tag     (wb_tag),
        .wb_data    (wb_data),
        .wb_err     (wb_err),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural EXE: answers the cycle after start; sub is b-a.
    always @(posedge clk) begin
        if (!rst_n) begin
            exe_valid  <= 1'b0;
            exe_result <= '0;
        end else begin
            exe_valid  <= exe_start && !exe_mute;
            exe_result <= (exe_op == 3'd1) ? (exe_b - exe_a) : (exe_a + exe_b);
        end
    end

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        prev_valid <= exe_valid;
        if (exe_start) begin
            prev_start_cyc <= last_start_cyc;
            last_start_cyc <= cyc;
            start_count    <= start_count + 1;
            if (prev_valid || exe_valid) gap_viol <= gap_viol + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    task automatic wait_wb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (wb_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_a     = '0;
        in_b     = '0;
        in_tag   = '0;
        wb_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({exe_start, exe_op, exe_a, exe_b, wb_valid, wb_tag, wb_data, wb_err, busy, err_cnt}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got start=%b op=%0d a=%0h b=%0h wbv=%b tag=%0h data=%0h err=%b busy=%b cnt=%0d want all 0",
                     exe_start, exe_op, exe_a, exe_b, wb_valid, wb_tag, wb_data, wb_err, busy,
                     err_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_latency();
        drive_op(3'd0, 32'd5, 32'd7, 4'd3);
        tick();
        in_valid = 1'b0;
        checks++;
        if (exe_start !== 1'b0) begin
            errors++;
            $display("FAIL add_start_t1: got %b want 0", exe_start);
        end
        tick();
        checks++;
        if ({exe_start, exe_op, exe_a, exe_b} !== {1'b0, 3'd0, 32'd5, 32'd7}) begin
            errors++;
            $display("FAIL add_setup_t2: got start=%b op=%0d a=%0d b=%0d want 0/0/5/7",
                     exe_start, exe_op, exe_a, exe_b);
        end
        tick();
        checks++;
        if ({exe_start, exe_a, exe_b} !== {1'b1, 32'd5, 32'd7}) begin
            errors++;
            $display("FAIL add_start_t3: got start=%b a=%0d b=%0d want 1/5/7",
                     exe_start, exe_a, exe_b);
        end
        tick();
        checks++;
        if ({exe_start, wb_valid} !== 2'b00) begin
            errors++;
            $display("FAIL add_wait_t4: got start=%b wbv=%b want 0/0", exe_start, wb_valid);
        end
        tick();
        checks++;
        if ({wb_valid, wb_tag, wb_data, wb_err} !== {1'b1, 4'd3, 32'd12, 1'b0}) begin
            errors++;
            $display("FAIL add_wb_t5: got v=%b tag=%0d data=%0d err=%b want 1/3/12/0",
                     wb_valid, wb_tag, wb_data, wb_err);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_wb_drop: got %b want 0", wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        settle();
        drive_op(3'd1, 32'd1, 32'd0, 4'd9);
        tick();
        drive_op(3'd0, 32'd10, 32'd20, 4'd4);
        tick();
        in_valid = 1'b0;
        wait_wb(ok);
        checks++;
        if (!ok || {wb_tag, wb_data, wb_err} !== {4'd9, 32'hFFFF_FFFF, 1'b0}) begin
            errors++;
            $display("FAIL sub_wrap: got ok=%b tag=%0d data=%0h err=%b want 1/9/ffffffff/0",
                     ok, wb_tag, wb_data, wb_err);
        end
        tick();
        wait_wb(ok);
        checks++;
        if (!ok || {wb_tag, wb_data, wb_err} !== {4'd4, 32'd30, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: got ok=%b tag=%0d data=%0d err=%b want 1/4/30/0",
                     ok, wb_tag, wb_data, wb_err);
        end
        checks++;
        if (last_start_cyc - prev_start_cyc !== 6) begin
            errors++;
            $display("FAIL b2b_start_spacing: got %0d want 6", last_start_cyc - prev_start_cyc);
        end
        checks++;
        if (gap_viol !== 0) begin
            errors++;
            $display("FAIL b2b_start_gap: got %0d violations want 0", gap_viol);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable;
        bit quiet;
        int accepted;
        logic rdy5;
        settle();
        wb_ready = 1'b0;
        accepted = 0;
        rdy5     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_op(3'd0, 32'(i), 32'd100, 4'(i + 1));
            if (in_ready) accepted++;
            if (i == 4) rdy5 = in_ready;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (accepted !== 4 || rdy5 !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: got accepted=%0d ready5=%b want 4/0", accepted, rdy5);
        end
        wait_wb(ok);
        stable = ok;
        for (int i = 0; i < 5; i++) begin
            if (!(wb_valid === 1'b1 && wb_tag === 4'd1 && wb_data === 32'd100 && wb_err === 1'b0))
                stable = 1'b0;
            tick();
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL wb_hold: got v=%b tag=%0d data=%0d want 1/1/100 held",
                     wb_valid, wb_tag, wb_data);
        end
        wb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_wb(ok);
            checks++;
            if (!ok || wb_tag !== 4'(k + 1) || wb_data !== 32'(100 + k)) begin
                errors++;
                $display("FAIL drain_%0d: got ok=%b tag=%0d data=%0d want tag=%0d data=%0d",
                         k, ok, wb_tag, wb_data, k + 1, 100 + k);
            end
            tick();
        end
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (wb_valid) quiet = 1'b0;
            tick();
        end
        checks++;
        if (!quiet || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_extra: got extra_wb=%b busy=%b want 0/0", !quiet, busy);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        int starts_before;
        settle();
        starts_before = start_count;
        drive_op(3'd5, 32'd1, 32'd2, 4'd2);
        tick();
        in_valid = 1'b0;
        wait_wb(ok);
        checks++;
        if (!ok || {wb_tag, wb_data, wb_err} !== {4'd2, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL illegal_wb: got ok=%b tag=%0d data=%0d err=%b want 1/2/0/1",
                     ok, wb_tag, wb_data, wb_err);
        end
        tick();
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL illegal_err_cnt: got %0d want 1", err_cnt);
        end
        checks++;
        if (start_count !== starts_before) begin
            errors++;
            $display("FAIL illegal_no_start: got %0d starts want %0d", start_count, starts_before);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        settle();
        exe_mute = 1'b1;
        drive_op(3'd0, 32'd1, 32'd2, 4'd6);
        tick();
        in_valid = 1'b0;
        wait_wb(ok);
        checks++;
        if (!ok || {wb_tag, wb_data, wb_err} !== {4'd6, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_wb: got ok=%b tag=%0d data=%0d err=%b want 1/6/0/1",
                     ok, wb_tag, wb_data, wb_err);
        end
        checks++;
        if (cyc - last_start_cyc !== 9) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d want 9 (start + 8 wait)", cyc - last_start_cyc);
        end
        tick();
        exe_mute = 1'b0;
        drive_op(3'd0, 32'd3, 32'd4, 4'd7);
        tick();
        in_valid = 1'b0;
        wait_wb(ok);
        checks++;
        if (!ok || {wb_tag, wb_data, wb_err} !== {4'd7, 32'd7, 1'b0}) begin
            errors++;
            $display("FAIL after_timeout: got ok=%b tag=%0d data=%0d err=%b want 1/7/7/0",
                     ok, wb_tag, wb_data, wb_err);
        end
        tick();
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL timeout_err_cnt: got %0d want 2", err_cnt);
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        bit quiet;
        settle();
        exe_mute = 1'b1;
        drive_op(3'd0, 32'd11, 32'd12, 4'd10);
        tick();
        drive_op(3'd1, 32'd13, 32'd14, 4'd11);
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (exe_start) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        tick();
        checks++;
        if (!seen || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: got started=%b busy=%b want 1/1", seen, busy);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({exe_start, exe_op, exe_a, exe_b, wb_valid, wb_tag, wb_data, wb_err, busy, err_cnt}
            !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_outputs: got start=%b op=%0d a=%0h b=%0h wbv=%b tag=%0h data=%0h err=%b busy=%b cnt=%0d rdy=%b want 0s rdy=1",
                     exe_start, exe_op, exe_a, exe_b, wb_valid, wb_tag, wb_data, wb_err, busy,
                     err_cnt, in_ready);
        end
        rst_n    = 1'b1;
        exe_mute = 1'b0;
        quiet    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (wb_valid || busy) quiet = 1'b0;
            tick();
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL rst_mid_abandon: got activity after reset want none");
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_timeout();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
